// File: rtl/alu_issue_queue.sv
// Instruction FIFO feeding an accumulator ALU one instruction at a time, with the
// ALU result returned on a valid/ready port once the ALU latency has elapsed.
module alu_issue_queue #(
    parameter int         DEPTH   = 8,
    parameter int         WIDTH   = 8,
    parameter int         ALU_LAT = 1,
    parameter logic [3:0] IDLE_OP = 4'h0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_opcode,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    output logic [3:0]                 alu_opcode,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    input  logic [WIDTH-1:0]           alu_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [3:0]                 out_opcode,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy,
    output logic                       err_illegal
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    typedef struct packed {
        logic [3:0]       opcode;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } instr_t;

    localparam instr_t IDLE_INSTR = '{opcode: IDLE_OP, a: '0, b: '0};

    instr_t           mem_q [DEPTH];
    instr_t           head, iss_q, iss_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [LW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [3:0]       out_opcode_q, out_opcode_d;
    logic             err_q, err_d;
    logic             push, pop, head_legal;

    assign in_ready   = (count_q < CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign head       = mem_q[rd_ptr_q];
    assign head_legal = (head.opcode <= 4'd8);

    always_comb begin
        state_d      = state_q;
        iss_d        = IDLE_INSTR;
        op_d         = op_q;
        wait_cnt_d   = wait_cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_opcode_d = out_opcode_q;
        err_d        = 1'b0;
        pop          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    if (head_legal) begin
                        iss_d   = head;
                        op_d    = head.opcode;
                        state_d = S_ISSUE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_q == LW'(ALU_LAT-1)) begin
                    out_data_d   = alu_result;
                    out_opcode_d = op_q;
                    out_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    // An illegal head is left for IDLE to discard and flag.
                    if (count_q != '0 && head_legal) begin
                        pop     = 1'b1;
                        iss_d   = head;
                        op_d    = head.opcode;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{opcode: in_opcode, a: in_a, b: in_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            iss_q        <= IDLE_INSTR;
            op_q         <= '0;
            wait_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_opcode_q <= '0;
            err_q        <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            iss_q        <= iss_d;
            op_q         <= op_d;
            wait_cnt_q   <= wait_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_opcode_q <= out_opcode_d;
            err_q        <= err_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    assign alu_opcode  = iss_q.opcode;
    assign alu_a       = iss_q.a;
    assign alu_b       = iss_q.b;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_opcode  = out_opcode_q;
    assign count       = count_q;
    assign busy        = (state_q != S_IDLE) || (count_q != '0);
    assign err_illegal = err_q;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: cycle-level accumulator ALU model on the alu_* port,
// sequential reference model feeding a scoreboard, negedge monitor doing the compares.
module tb_alu_issue_queue;
    localparam logic [3:0] IDLE_OP = 4'h0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_opcode = '0;
    logic [7:0] in_a = '0, in_b = '0;
    logic [3:0] alu_opcode;
    logic [7:0] alu_a, alu_b;
    logic [7:0] alu_result = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [3:0] out_opcode;
    logic [3:0] count;
    logic       busy;
    logic       err_illegal;

    alu_issue_queue #(.DEPTH(8), .WIDTH(8), .ALU_LAT(1), .IDLE_OP(IDLE_OP)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_opcode(out_opcode), .count(count), .busy(busy), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU: 0 ADD 1 SUB 2 MUL 3 AND 4 OR 5 ADDA 6 MULA 7 MAC 8 ROR
    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] acc);
        logic [15:0] t;
        case (op)
            4'd0: alu_f = a + b;
            4'd1: alu_f = a - b;
            4'd2: alu_f = a * b;
            4'd3: alu_f = a & b;
            4'd4: alu_f = a | b;
            4'd5: alu_f = acc + a;
            4'd6: alu_f = acc * a;
            4'd7: alu_f = acc + a * b;
            4'd8: begin t = {a, a} >> b[2:0]; alu_f = t[7:0]; end
            default: alu_f = '0;
        endcase
    endfunction

    function automatic logic is_acc(input logic [3:0] op);
        return (op == 4'd5) || (op == 4'd6) || (op == 4'd7);
    endfunction

    // ALU stand-in: samples the bus every edge, accumulator never reset by the queue
    logic [7:0] alu_acc = '0;
    always @(posedge clk) begin
        alu_result <= alu_f(alu_opcode, alu_a, alu_b, alu_acc);
        if (is_acc(alu_opcode)) alu_acc <= alu_f(alu_opcode, alu_a, alu_b, alu_acc);
    end

    typedef struct packed { logic [3:0] op; logic [7:0] d; } exp_t;
    exp_t       exp_q[$];
    logic [7:0] m_acc = '0;
    int         exp_err = 0;

    task automatic model_push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        if (op > 4'd8) begin
            exp_err++;
        end else begin
            r = alu_f(op, a, b, m_acc);
            if (is_acc(op)) m_acc = r;
            exp_q.push_back('{op: op, d: r});
        end
    endtask

    // Monitor
    int         err_seen = 0, issue_cycles = 0, n_results = 0;
    logic [7:0] last_data = '0;
    initial begin
        exp_t       e;
        logic       prev_hold;
        logic [7:0] prev_data;
        logic [3:0] prev_op;
        prev_hold = 1'b0; prev_data = '0; prev_op = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (err_illegal) err_seen++;
                if (alu_opcode != IDLE_OP || alu_a != 8'h00 || alu_b != 8'h00) issue_cycles++;
                if (prev_hold) begin
                    check("hold_valid", out_valid, 1'b1);
                    check("hold_data", out_data, prev_data);
                    check("hold_opcode", out_opcode, prev_op);
                end
                if (out_valid && out_ready) begin
                    n_results++;
                    last_data = out_data;
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_result: got 0x%0h expected none at %0t", out_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("result_data", out_data, e.d);
                        check("result_opcode", out_opcode, e.op);
                    end
                end
                prev_hold = out_valid && !out_ready;
                prev_data = out_data;
                prev_op   = out_opcode;
            end
        end
    end

    bit rnd_rdy = 1'b0;

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            if (rnd_rdy) out_ready = ($urandom % 3) != 0;
            @(negedge clk);
            n++;
        end
        check("push_accept", in_ready, 1'b1);
        if (in_ready) model_push(op, a, b);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 1000) begin
            @(posedge clk); n++;
        end
        #1;
        check("drain_in_time", (n < 1000), 1'b1);
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        check("wait_valid", out_valid, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, e0, ic0;
        // 1 reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_opcode", out_opcode, 4'h0);
        check("rst_count", count, 4'd0);
        check("rst_err", err_illegal, 1'b0);
        check("rst_alu_opcode", alu_opcode, IDLE_OP);
        check("rst_alu_ab", {alu_a, alu_b}, 16'h0000);
        check("rst_busy", busy, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // 2 single ADD, exact latency
        out_ready = 1'b1;
        push(4'd0, 8'h0A, 8'h05);
        @(negedge clk);
        check("lat_idle_valid", out_valid, 1'b0);
        check("lat_idle_count", count, 4'd1);
        @(negedge clk);
        check("lat_issue_op", alu_opcode, 4'd0);
        check("lat_issue_ab", {alu_a, alu_b}, 16'h0A05);
        @(negedge clk);
        check("lat_wait_valid", out_valid, 1'b0);
        check("lat_wait_ab", {alu_a, alu_b}, 16'h0000);
        @(negedge clk);
        check("lat_resp_valid", out_valid, 1'b1);
        check("lat_resp_data", out_data, 8'h0F);
        check("lat_resp_op", out_opcode, 4'd0);
        @(posedge clk); #1;
        drain();

        // 3 fill with SUBs under backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++)
            push(4'd1, (i == 0) ? 8'h00 : 8'($urandom), (i == 0) ? 8'h01 : 8'($urandom));
        in_valid = 1'b1; in_opcode = 4'd1; in_a = 8'h05; in_b = 8'h03;
        @(negedge clk);
        check("full_count", count, 4'd8);
        check("full_in_ready", in_ready, 1'b0);
        check("full_out_valid", out_valid, 1'b1);
        check("full_first_ff", out_data, 8'hFF);
        @(posedge clk); #1;
        out_ready = 1'b1;
        push(4'd1, 8'h05, 8'h03);
        drain();

        // 4 backpressure hold
        out_ready = 1'b0;
        push(4'd2, 8'h03, 8'h05);
        push(4'd3, 8'hF0, 8'h3C);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_alu_idle", {alu_opcode, alu_a, alu_b}, {IDLE_OP, 16'h0000});
            check("bp_count", count, 4'd1);
            check("bp_data", out_data, 8'h0F);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // 5 accumulate: exactly one ALU issue per instruction
        ic0 = issue_cycles;
        push(4'd6, 8'h00, 8'h00);
        push(4'd5, 8'h02, 8'h00);
        push(4'd5, 8'h0A, 8'h00);
        drain();
        check("acc_issue_cycles", issue_cycles - ic0, 3);
        check("acc_result", last_data, 8'h0C);

        // 6 illegal opcode discarded
        e0 = err_seen; r0 = n_results;
        push(4'hF, 8'h01, 8'h02);
        push(4'd0, 8'h01, 8'h01);
        drain();
        check("ill_err_pulses", err_seen - e0, 1);
        check("ill_results", n_results - r0, 1);
        check("ill_result", last_data, 8'h02);

        // reset during WAIT
        push(4'd0, 8'h03, 8'h04);
        begin
            int n = 0;
            @(negedge clk);
            while (alu_a != 8'h03 && n < 20) begin @(negedge clk); n++; end
            check("mid_issue_seen", alu_a, 8'h03);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_count", count, 4'd0);
        check("mid_rst_busy", busy, 1'b0);
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        r0 = n_results;
        push(4'd0, 8'h02, 8'h02);
        drain();
        check("post_rst_results", n_results - r0, 1);

        // random mix
        rnd_rdy = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic [3:0] op;
            op = (($urandom % 8) == 0) ? 4'(9 + $urandom % 7) : 4'($urandom % 9);
            out_ready = ($urandom % 3) != 0;
            push(op, 8'($urandom), 8'($urandom));
            repeat ($urandom % 3) begin @(posedge clk); #1; end
        end
        rnd_rdy = 1'b0;
        out_ready = 1'b1;
        drain();
        check("total_err_pulses", err_seen, exp_err);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
